// File: rtl/conv_pool_sched.sv
// Sequencer for the binary conv-pool datapath: buffers a full input map, walks 6x6 windows at stride 2,
// captures one pooled pixel per window and streams it out. Optional `CONV_POOL_SCHED_ERR_EN adds a sticky err flag.
module conv_pool_sched #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int OFF_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OFF_W-1:0] cfg_offset,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMG_W-1:0] in_row,
  output logic [35:0]      dp_win,
  output logic [OFF_W-1:0] dp_offset,
  output logic             dp_valid,
  input  logic             dp_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pixel,
  output logic             out_last,
  output logic [2:0]       dbg_state
`ifdef CONV_POOL_SCHED_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int OUT_W = (IMG_W - 6) / 2 + 1;
  localparam int OUT_H = (IMG_H - 6) / 2 + 1;
  localparam int RIW   = $clog2(IMG_H);
  localparam int CIW   = $clog2(IMG_W);
  localparam int RRW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_pixel/out_last are held stable while out_valid is high and out_ready is low.
  state_t           state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [RIW-1:0]   row_q, row_d;
  logic [RRW-1:0]   wr_q, wr_d;
  logic [CCW-1:0]   wc_q, wc_d;
  logic [35:0]      win_q, win_d;
  logic             pix_q, pix_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [IMG_W-1:0] buf_q [IMG_H];
  logic [35:0]      win_sel;

  always_comb begin : win_mux
    logic [RIW-1:0] ri;
    logic [CIW-1:0] ci;
    win_sel = '0;
    ri      = '0;
    ci      = '0;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        ri = RIW'(2 * int'(wr_q) + i);
        ci = CIW'(2 * int'(wc_q) + j);
        win_sel[6*i+j] = buf_q[ri][ci];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    row_d   = row_q;
    wr_d    = wr_q;
    wc_d    = wc_q;
    win_d   = win_q;
    pix_d   = pix_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d   = cfg_offset;
          row_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          row_d = row_q + 1'b1;
          if (row_q == RIW'(IMG_H - 1)) begin
            row_d   = '0;
            wr_d    = '0;
            wc_d    = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        win_d   = win_sel;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        pix_d   = dp_pixel;
        last_d  = (wr_q == RRW'(OUT_H - 1)) && (wc_q == CCW'(OUT_W - 1));
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Row-major walk: column wraps into the next window row.
            if (wc_q == CCW'(OUT_W - 1)) begin
              wc_d = '0;
              wr_d = wr_q + 1'b1;
            end else begin
              wc_d = wc_q + 1'b1;
            end
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      row_q   <= '0;
      wr_q    <= '0;
      wc_q    <= '0;
      win_q   <= '0;
      pix_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      wc_q    <= wc_d;
      win_q   <= win_d;
      pix_q   <= pix_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // The map buffer is never cleared: every job rewrites all rows before the first window.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_LOAD && in_valid) begin
      buf_q[row_q] <= in_row;
    end
  end

`ifdef CONV_POOL_SCHED_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((start && state_q != S_IDLE) || (in_valid && state_q != S_LOAD)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`endif

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign dp_valid  = (state_q == S_CAPTURE);
  assign out_valid = (state_q == S_EMIT);
  assign done      = done_q;
  assign dp_win    = win_q;
  assign dp_offset = off_q;
  assign out_pixel = pix_q;
  assign out_last  = last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_pool_sched.sv
// Bench for conv_pool_sched: job-level reference model of the map, windows and handshake timing,
// checked every cycle on the falling edge, with a few hand-computed literal pins.
module tb_conv_pool_sched;
  localparam int IMG_W = 14;
  localparam int IMG_H = 14;
  localparam int OFF_W = 7;
  localparam int OUT_W = (IMG_W - 6) / 2 + 1;
  localparam int OUT_H = (IMG_H - 6) / 2 + 1;
  localparam int N     = OUT_W * OUT_H;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [OFF_W-1:0] cfg_offset;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [IMG_W-1:0] in_row;
  logic [35:0]      dp_win;
  logic [OFF_W-1:0] dp_offset;
  logic             dp_valid;
  logic             dp_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             out_pixel;
  logic             out_last;
  logic [2:0]       dbg_state;
`ifdef CONV_POOL_SCHED_ERR_EN
  logic             err;
`endif

  conv_pool_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_offset(cfg_offset),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .dp_win(dp_win), .dp_offset(dp_offset), .dp_valid(dp_valid), .dp_pixel(dp_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last),
    .dbg_state(dbg_state)
`ifdef CONV_POOL_SCHED_ERR_EN
    , .err(err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath stand-in ----------------
  int mode;
  function automatic logic dp_model(input int md, input logic [35:0] w, input logic [OFF_W-1:0] off);
    if (md == 0) return w[0];
    return ($countones(w) >= int'(off));
  endfunction
  assign dp_pixel = dp_model(mode, dp_win, dp_offset);

  // ---------------- reference model (job level) ----------------
  int               cyc, start_cyc;
  int               m_phase, m_rows, m_k, m_t;
  logic             m_done, m_rst, m_err;
  logic [OFF_W-1:0] m_off;
  logic [IMG_W-1:0] m_map [IMG_H];

  function automatic logic [35:0] exp_window(input int k);
    logic [35:0] w;
    int r0, c0;
    r0 = 2 * (k / OUT_W);
    c0 = 2 * (k % OUT_W);
    w  = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        w[6*i+j] = m_map[r0+i][c0+j];
    return w;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_rows = 0; m_k = 0; m_t = 0;
      m_off = '0; m_err = 1'b0; m_done = 1'b0; m_rst = 1'b1;
    end else begin
      m_rst  = 1'b0;
      m_done = 1'b0;
      if ((start && m_phase != 0) || (in_valid && m_phase != 1)) m_err = 1'b1;
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_rows = 0; m_off = cfg_offset; start_cyc = cyc;
        end
        1: if (in_valid) begin
          m_map[m_rows] = in_row;
          m_rows++;
          if (m_rows == IMG_H) begin m_phase = 2; m_k = 0; m_t = 0; end
        end
        default: begin
          if (m_t >= 2 && out_ready) begin
            if (m_k == N - 1) begin m_phase = 0; m_done = 1'b1; end
            else begin m_k++; m_t = 0; end
          end else begin
            m_t++;
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  int         n_checks, n_fails;
  bit         checking;
  int         lit_mode;
  int         ohs_job, ones_job, wd;
  logic [1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      if (m_rst) begin
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0); chk("rst_dp_valid", dp_valid, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_last", out_last, 0); chk("rst_dp_win", dp_win, 0);
        chk("rst_dp_offset", dp_offset, 0);
`ifdef CONV_POOL_SCHED_ERR_EN
        chk("rst_err", err, 0);
`endif
        exp_q.delete();
        ohs_job = 0; ones_job = 0; wd = 0;
      end else begin
        chk("busy", busy, m_phase != 0);
        chk("in_ready", in_ready, m_phase == 1);
        chk("dp_valid", dp_valid, m_phase == 2 && m_t == 1);
        chk("out_valid", out_valid, m_phase == 2 && m_t >= 2);
        chk("done", done, m_done);
        chk("dp_offset", dp_offset, m_off);
`ifdef CONV_POOL_SCHED_ERR_EN
        chk("err", err, m_err);
`endif
        if (m_phase == 2 && m_t == 1) begin
          chk("dp_win", dp_win, exp_window(m_k));
          if (lit_mode == 2 && m_k == 0) chk("win0_literal", dp_win, 36'h8_1020_4081);
          exp_q.push_back({m_k == N - 1, dp_model(mode, exp_window(m_k), m_off)});
        end
        if (m_phase == 2 && m_t >= 2) begin
          chk("scoreboard_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk("out_pixel", out_pixel, exp_q[0][0]);
            chk("out_last", out_last, exp_q[0][1]);
            if (out_ready) void'(exp_q.pop_front());
          end
          if (out_ready) begin ohs_job++; ones_job += int'(out_pixel); end
        end
        if (m_done) begin
          chk("outputs_per_job", ohs_job, N);
          if (lit_mode == 1) begin
            chk("order_ones", ones_job, 0);
            chk("job_latency", cyc - start_cyc, IMG_H + 3 * N);
          end
`ifdef CONV_POOL_SCHED_ERR_EN
          if (lit_mode == 3) chk("err_literal", err, 1);
`endif
          ohs_job = 0; ones_job = 0;
        end
        wd = (m_phase != 0) ? wd + 1 : 0;
        if (wd == 3000) chk("job_timeout_cycles", wd, 0);
      end
    end
  end

  // ---------------- output consumer ----------------
  bit stall_on, rand_ready;
  int c_hs, st_cnt;
  logic ov;
  initial begin
    out_ready = 1'b1;
    c_hs = 0; st_cnt = 0;
    forever begin
      @(negedge clk);
      ov = out_valid;
      if (start) begin c_hs = 0; st_cnt = 0; end
      else if (out_valid && out_ready) c_hs++;
      @(posedge clk); #1;
      if (stall_on && c_hs == 2 && st_cnt < 5) begin
        out_ready = 1'b0;
        if (ov) st_cnt++;
      end else if (rand_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [IMG_W-1:0] rows [IMG_H];

  task automatic load_rows(input bit throttle, input bit err_pulse);
    int  idx;
    bit  hs;
    idx = 0;
    for (int g = 0; g < 400 && idx < IMG_H; g++) begin
      in_row   = rows[idx];
      in_valid = throttle ? (g % 2 == 1) : 1'b1;
      start    = err_pulse && (g == 3);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    for (int i = 0; i < 4000; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_row   = IMG_W'($urandom);
      end
      @(negedge clk);
      if (m_phase == 0) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [OFF_W-1:0] off, input bit throttle, input bit noise,
                         input bit err_pulse, input bit gap);
    start      = 1'b1;
    cfg_offset = off;
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_offset = OFF_W'($urandom);
    load_rows(throttle, err_pulse);
    wait_idle(noise);
    if (gap) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_rows();
    for (int r = 0; r < IMG_H; r++) rows[r] = IMG_W'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_offset = '0; in_valid = 1'b0; in_row = '0;
    mode = 0; lit_mode = 0; stall_on = 1'b0; rand_ready = 1'b0; checking = 1'b0;
    n_checks = 0; n_fails = 0; cyc = 0; start_cyc = 0;
    repeat (3) @(posedge clk);
    #1; checking = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // window order: checkerboard map, datapath returns window bit 0
    mode = 0; lit_mode = 1;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) rows[r][c] = 1'((r + c) & 1);
    run_job(OFF_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);

    // window content: one-hot diagonal rows
    mode = 1; lit_mode = 2;
    for (int r = 0; r < IMG_H; r++) rows[r] = IMG_W'(1) << r;
    run_job(7'd19, 1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure on the third pixel
    lit_mode = 0; stall_on = 1'b1;
    rand_rows();
    run_job(OFF_W'($urandom_range(12, 24)), 1'b0, 1'b0, 1'b0, 1'b1);
    stall_on = 1'b0;

    // reset during window 10 emit, then a clean job
    rand_rows();
    start = 1'b1; cfg_offset = OFF_W'($urandom_range(12, 24));
    @(posedge clk); #1; start = 1'b0;
    load_rows(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_phase == 2 && m_k == 9 && m_t >= 2) break;
    end
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rand_rows();
    run_job(OFF_W'($urandom_range(12, 24)), 1'b0, 1'b0, 1'b0, 1'b1);

    // protocol violation: start pulsed during load
    lit_mode = 3;
    rand_rows();
    run_job(OFF_W'($urandom_range(12, 24)), 1'b0, 1'b0, 1'b1, 1'b1);
    lit_mode = 0;

    // load throttling with random consumer and in_valid noise outside load
    rand_ready = 1'b1;
    rand_rows();
    run_job(OFF_W'($urandom_range(12, 24)), 1'b1, 1'b1, 1'b0, 1'b1);

    // random jobs; the first two restart in the done cycle
    for (int j = 0; j < 3; j++) begin
      rand_rows();
      run_job(OFF_W'($urandom_range(10, 26)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, j == 2);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
